j_mtxread: RTL and testbench

//  Matrix operand read sequencer for the Jerry systolic MMULT path; the read-side counterpart of the

---
 rtl/j_mtxread.sv | 114 +++++++++++
 tb/tb_j_mtxread.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/j_mtxread.sv
// Matrix operand read sequencer: emits one long-word read address per accepted request.
// Optional abort port enabled by defining J_MTXREAD_ABORT_EN.
module j_mtxread #(
  parameter int AW = 24,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          resetl,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [CW-2:0] width,
  input  logic          colmode,
  output logic          rd_req,
  output logic [AW-1:0] rd_addr,
  output logic          rd_last,
  input  logic          rd_ack,
  output logic          busy,
  output logic          done
`ifdef J_MTXREAD_ABORT_EN
  ,
  input  logic          abort
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr;
  logic [AW-1:0] stride;
  logic [CW-1:0] remaining;
  logic          kill;
  logic          launch;
  logic          last_elem;

`ifdef J_MTXREAD_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  // Abort in IDLE outranks start, so a simultaneous start is dropped.
  assign launch    = (state == IDLE) && start && !kill;
  assign last_elem = (remaining == CW'(1));

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (launch) begin
          state_nxt = (width != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (kill) begin
          state_nxt = IDLE;
        end else if (rd_ack && last_elem) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      addr      <= '0;
      remaining <= '0;
      stride    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            addr      <= base & {{(AW-2){1'b1}}, 2'b00};
            remaining <= {1'b0, width};
            stride    <= colmode ? {{(AW-CW-1){1'b0}}, width, 2'b00} : AW'(4);
          end
        end
        RUN: begin
          if (kill) begin
            remaining <= '0;
          end else if (rd_ack) begin
            addr      <= addr + stride;
            remaining <= remaining - CW'(1);
          end
        end
        default: begin
          if (kill) begin
            remaining <= '0;
          end
        end
      endcase
    end
  end

  assign rd_req  = (state == RUN);
  assign rd_addr = addr;
  assign rd_last = (state == RUN) && last_elem;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_j_mtxread.sv
// Randomized bench for j_mtxread against an address-list reference model.
module tb_j_mtxread;
  localparam int AW = 24;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          resetl;
  logic          start;
  logic [AW-1:0] base;
  logic [CW-2:0] width;
  logic          colmode;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_last;
  logic          rd_ack;
  logic          busy;
  logic          done;
`ifdef J_MTXREAD_ABORT_EN
  logic          abort;
`endif

  int total = 0;
  int bad   = 0;

  j_mtxread #(.AW(AW), .CW(CW)) dut (
    .clk     (clk),
    .resetl  (resetl),
    .start   (start),
    .base    (base),
    .width   (width),
    .colmode (colmode),
    .rd_req  (rd_req),
    .rd_addr (rd_addr),
    .rd_last (rd_last),
    .rd_ack  (rd_ack),
    .busy    (busy),
    .done    (done)
`ifdef J_MTXREAD_ABORT_EN
    ,
    .abort   (abort)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: i-th element address = aligned base + i*stride, modulo 2^AW.
  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] b, input int unsigned w,
                                              input logic c, input int unsigned i);
    int unsigned s;
    logic [31:0] t;
    s = c ? w * 4 : 4;
    t = (32'(b) & ~32'd3) + i * s;
    return t[AW-1:0];
  endfunction

  // mode 0: always ack, 1: random ack, 2: stall first two cycles
  task automatic run_seq(input logic [AW-1:0] b, input int unsigned w, input logic c,
                         input int mode);
    logic [AW-1:0] q[$];
    logic          ack;
    int            guard;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_req", 32'(rd_req), 32'd0);
    base    = b;
    width   = (CW-1)'(w);
    colmode = c;
    start   = 1'b1;
    rd_ack  = 1'($urandom_range(0, 1));
    for (int unsigned i = 0; i < w; i++) q.push_back(exp_addr(b, w, c, i));
    @(negedge clk);
    guard = 0;
    while (q.size() > 0 && guard < 200) begin
      chk("rd_req", 32'(rd_req), 32'd1);
      chk("rd_addr", 32'(rd_addr), 32'(q[0]));
      chk("rd_last", 32'(rd_last), 32'(q.size() == 1));
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_run", 32'(done), 32'd0);
      case (mode)
        0:       ack = 1'b1;
        1:       ack = ($urandom_range(0, 3) != 0);
        default: ack = (guard >= 2);
      endcase
      rd_ack  = ack;
      start   = 1'($urandom_range(0, 1));
      base    = AW'($urandom);
      width   = (CW-1)'($urandom);
      colmode = 1'($urandom);
      @(negedge clk);
      if (ack) void'(q.pop_front());
      guard++;
    end
    if (q.size() != 0) chk("timeout", 32'(q.size()), 32'd0);
    rd_ack = 1'($urandom_range(0, 1));
    start  = 1'($urandom_range(0, 1));
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_req", 32'(rd_req), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
    @(negedge clk);
    start  = 1'b0;
    rd_ack = 1'b0;
    chk("post_done", 32'(done), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_req", 32'(rd_req), 32'd0);
  endtask

  initial begin
    resetl = 1'b1; start = 1'b0; base = '0; width = '0; colmode = 1'b0; rd_ack = 1'b0;
`ifdef J_MTXREAD_ABORT_EN
    abort = 1'b0;
`endif
    #3 resetl = 1'b0;
    #1;
    chk("rst_req", 32'(rd_req), 32'd0);
    chk("rst_addr", 32'(rd_addr), 32'd0);
    chk("rst_last", 32'(rd_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetl = 1'b1;

    run_seq(24'hF1B000, 4, 1'b0, 0);
    run_seq(24'h000100, 3, 1'b1, 0);
    run_seq(24'h000200, 2, 1'b0, 2);
    run_seq(24'h123456, 0, 1'b1, 0);
    run_seq(24'hFFFFFC, 2, 1'b0, 0);
    run_seq(24'hFFFFF3, 31, 1'b1, 1);

    // Reset after the second of five acks
    @(negedge clk);
    base = 24'h000400; width = 5; colmode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rd_ack = 1'b1;
    chk("rr_addr0", 32'(rd_addr), 32'h000400);
    @(negedge clk);
    chk("rr_addr1", 32'(rd_addr), 32'h000404);
    @(negedge clk);
    chk("rr_addr2", 32'(rd_addr), 32'h000408);
    #2 resetl = 1'b0;
    #1;
    chk("rr_req", 32'(rd_req), 32'd0);
    chk("rr_addr", 32'(rd_addr), 32'd0);
    chk("rr_last", 32'(rd_last), 32'd0);
    chk("rr_busy", 32'(busy), 32'd0);
    chk("rr_done", 32'(done), 32'd0);
    @(negedge clk);
    rd_ack = 1'b0;
    resetl = 1'b1;

`ifdef J_MTXREAD_ABORT_EN
    @(negedge clk);
    base = 24'h000800; width = 5; colmode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rd_ack = 1'b1;
    @(negedge clk);
    chk("ab_addr1", 32'(rd_addr), 32'h000804);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; rd_ack = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_req", 32'(rd_req), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("ab_done2", 32'(done), 32'd0);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("ab_idle_start", 32'(busy), 32'd0);
`endif

    for (int n = 0; n < 40; n++) begin
      run_seq(AW'($urandom), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31),
              1'($urandom), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
